// File: rtl/tdm_mux_if.sv
// rtl/tdm_mux_if.sv - channel data, control and sample handshake bundle for tdm_mux
interface tdm_mux_if #(
    parameter int N = 8,
    parameter int W = 1
);
    localparam int SW = $clog2(N);

    logic [N*W-1:0] din;
    logic [SW-1:0]  sel;
    logic           mode;
    logic           en;
    logic           out_ready;
    logic [W-1:0]   dout;
    logic [SW-1:0]  dout_ch;
    logic           dout_valid;
    logic           wrap;

    modport master (
        output din, sel, mode, en, out_ready,
        input  dout, dout_ch, dout_valid, wrap
    );

    modport slave (
        input  din, sel, mode, en, out_ready,
        output dout, dout_ch, dout_valid, wrap
    );
endinterface

// File: rtl/tdm_mux.sv
// rtl/tdm_mux.sv - N-channel time-division mux, direct or auto-scan, single-entry output register
module tdm_mux #(
    parameter  int N  = 8,
    parameter  int W  = 1,
    localparam int SW = $clog2(N)
) (
    input  logic      clk,
    input  logic      rst,
    tdm_mux_if.slave  bus
);
    logic [W-1:0]  ch_data [N];
    logic          cap;
    logic [SW-1:0] src_ch;

    logic [W-1:0]  dout_q,    dout_d;
    logic [SW-1:0] dout_ch_q, dout_ch_d;
    logic          valid_q,   valid_d;
    logic          wrap_q,    wrap_d;
    logic [SW-1:0] scan_ch_q, scan_ch_d;

    for (genvar k = 0; k < N; k++) begin : g_ch
        assign ch_data[k] = bus.din[k*W +: W];
    end

    // The output register takes a new sample whenever it is empty or being drained this cycle.
    always_comb begin
        cap       = bus.en & (~valid_q | bus.out_ready);
        src_ch    = bus.mode ? scan_ch_q : bus.sel;
        dout_d    = dout_q;
        dout_ch_d = dout_ch_q;
        valid_d   = valid_q;
        wrap_d    = 1'b0;
        scan_ch_d = scan_ch_q;

        if (cap) begin
            dout_d    = ch_data[src_ch];
            dout_ch_d = src_ch;
            valid_d   = 1'b1;
            wrap_d    = bus.mode & (scan_ch_q == SW'(N-1));
        end else if (bus.out_ready) begin
            valid_d   = 1'b0;
        end

        // Direct mode parks the scan pointer so each scan entry starts at channel 0.
        if (!bus.mode) begin
            scan_ch_d = '0;
        end else if (cap) begin
            scan_ch_d = scan_ch_q + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q    <= '0;
            dout_ch_q <= '0;
            valid_q   <= 1'b0;
            wrap_q    <= 1'b0;
            scan_ch_q <= '0;
        end else begin
            dout_q    <= dout_d;
            dout_ch_q <= dout_ch_d;
            valid_q   <= valid_d;
            wrap_q    <= wrap_d;
            scan_ch_q <= scan_ch_d;
        end
    end

    assign bus.dout       = dout_q;
    assign bus.dout_ch    = dout_ch_q;
    assign bus.dout_valid = valid_q;
    assign bus.wrap       = wrap_q;
endmodule

// File: tb/tb_tdm_mux.sv
// tb/tb_tdm_mux.sv - directed scenarios plus randomized traffic against a behavioural model of tdm_mux
module tb_tdm_mux;
    localparam int N = 8;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    tdm_mux_if #(.N(N), .W(W)) bus ();

    tdm_mux #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int vectors    = 0;
    int miscompares = 0;

    // Model of the observable sample register and the hidden scan position.
    int m_dout, m_ch, m_valid, m_wrap, m_scan;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [N*W-1:0] ramp_din();
        logic [N*W-1:0] v;
        v = '0;
        for (int k = 0; k < N; k++) v[k*W +: W] = W'(k + 1);
        return v;
    endfunction

    // Advance one clock, update the model from the inputs seen at that edge, then compare.
    task automatic cycle();
        bit take;
        int src;
        @(posedge clk);
        if (rst) begin
            m_dout = 0; m_ch = 0; m_valid = 0; m_wrap = 0; m_scan = 0;
        end else begin
            take   = bus.en && (m_valid == 0 || bus.out_ready);
            m_wrap = 0;
            if (take) begin
                src     = bus.mode ? m_scan : int'(bus.sel);
                m_dout  = int'((bus.din >> (src * W)) & ((1 << W) - 1));
                m_ch    = src;
                m_valid = 1;
                m_wrap  = (bus.mode && src == N - 1) ? 1 : 0;
            end else if (bus.out_ready) begin
                m_valid = 0;
            end
            if (!bus.mode) m_scan = 0;
            else if (take) m_scan = (m_scan + 1) % N;
        end
        #1;
        chk("m_dout",  32'(bus.dout),       m_dout);
        chk("m_ch",    32'(bus.dout_ch),    m_ch);
        chk("m_valid", 32'(bus.dout_valid), m_valid);
        chk("m_wrap",  32'(bus.wrap),       m_wrap);
    endtask

    task automatic drive(input bit r, input bit md, input bit e, input bit rdy, input int s);
        rst           = r;
        bus.mode      = md;
        bus.en        = e;
        bus.out_ready = rdy;
        bus.sel       = 3'(s);
    endtask

    initial begin
        bus.din = ramp_din();
        drive(1, 0, 0, 0, 0);
        m_dout = 0; m_ch = 0; m_valid = 0; m_wrap = 0; m_scan = 0;
        cycle();
        cycle();
        chk("rst_dout",  32'(bus.dout),       0);
        chk("rst_valid", 32'(bus.dout_valid), 0);
        chk("rst_wrap",  32'(bus.wrap),       0);

        // Direct select of channel 5.
        drive(0, 0, 1, 1, 5);
        cycle();
        chk("dir_dout",  32'(bus.dout),       6);
        chk("dir_ch",    32'(bus.dout_ch),    5);
        chk("dir_valid", 32'(bus.dout_valid), 1);

        // Free-flowing scan across a full rotation plus one.
        drive(0, 1, 1, 1, 5);
        for (int i = 0; i < 9; i++) begin
            cycle();
            chk("scan_ch",   32'(bus.dout_ch), i % N);
            chk("scan_dout", 32'(bus.dout),    (i % N) + 1);
            chk("scan_wrap", 32'(bus.wrap),    (i % N == N - 1) ? 1 : 0);
        end

        // Backpressure while channel 3 is held.
        for (int i = 1; i <= 3; i++) cycle();
        chk("bp_pre_ch", 32'(bus.dout_ch), 3);
        drive(0, 1, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_hold_ch",    32'(bus.dout_ch),    3);
            chk("bp_hold_valid", 32'(bus.dout_valid), 1);
        end
        drive(0, 1, 1, 1, 0);
        cycle();
        chk("bp_next_ch", 32'(bus.dout_ch), 4);

        // Mode toggle: scan to 5, one direct capture of 2, rescan from 0.
        cycle();
        chk("tog_pre_ch", 32'(bus.dout_ch), 5);
        drive(0, 0, 1, 1, 2);
        cycle();
        chk("tog_dir_ch", 32'(bus.dout_ch), 2);
        chk("tog_dir_d",  32'(bus.dout),    3);
        drive(0, 1, 1, 1, 2);
        cycle();
        chk("tog_s0_ch", 32'(bus.dout_ch), 0);
        cycle();
        chk("tog_s1_ch", 32'(bus.dout_ch), 1);

        // Reset with channel 6 pending.
        for (int i = 0; i < 5; i++) cycle();
        chk("rm_pre_ch",    32'(bus.dout_ch),    6);
        chk("rm_pre_valid", 32'(bus.dout_valid), 1);
        drive(1, 1, 1, 1, 0);
        cycle();
        chk("rm_dout",  32'(bus.dout),       0);
        chk("rm_ch",    32'(bus.dout_ch),    0);
        chk("rm_valid", 32'(bus.dout_valid), 0);
        drive(0, 1, 1, 1, 0);
        cycle();
        chk("rm_first_ch",  32'(bus.dout_ch), 0);
        chk("rm_first_d",   32'(bus.dout),    1);

        // Idle drain: sample leaves, data holds, scan position holds.
        drive(0, 1, 0, 1, 0);
        cycle();
        chk("idle_valid", 32'(bus.dout_valid), 0);
        chk("idle_dout",  32'(bus.dout),       1);
        cycle();
        drive(0, 1, 1, 1, 0);
        cycle();
        chk("idle_next_ch", 32'(bus.dout_ch), 1);

        // Randomized traffic including mode flips, stalls and occasional reset.
        for (int i = 0; i < 400; i++) begin
            bus.din = N*W'($urandom);
            drive(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
                  ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0),
                  int'($urandom_range(0, N - 1)));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
